reduce_lane_collector: RTL and testbench

Upstream feeder for the half-precision adder tree. It accepts a serial stream of 16-bit operands tagged with a source lane from the MPI reduce path and buffers them in per-lane FIFOs. Once every lane holds an operand, it emits one aligned N-wide vector in the adder tree's idata/ivalid format. A flush mechanism drains partial sets, zero-filling the missing lanes.

---
 rtl/reduce_lane_collector.sv | 161 ++++++++++++++++
 tb/tb_reduce_lane_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_lane_collector.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_lane_collector
//  Description : Per-lane FIFO collector that aligns tagged operands into
//                N-wide vectors for the half-precision adder tree, with a
//                zero-filling flush. Optional COLLECTOR_STATS_EN adds counters.
//  Revision    : 1.0  initial release
// ============================================================================
module reduce_lane_collector #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int SRC_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [15:0]       in_data,
    input  logic [SRC_W-1:0]  in_src,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic [16*N-1:0]   odata,
    output logic [N-1:0]      ovalid,
    output logic              opartial,
    output logic              err_src
`ifdef COLLECTOR_STATS_EN
    ,
    output logic [31:0]       stat_vectors,
    output logic [31:0]       stat_stall
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [SRC_W:0]   c_LANES = N[SRC_W:0];

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_mem    [N][DEPTH];
    logic [PTR_W-1:0] r_rd_ptr [N];
    logic [PTR_W-1:0] r_wr_ptr [N];
    logic [CNT_W-1:0] r_count  [N];

    logic [N-1:0]     w_empty, w_full, w_sel, w_push, w_pop;
    logic             w_src_ok, w_accept, w_bad;
    logic             w_emit, w_partial, w_done;
    logic [16*N-1:0]  w_vec;

    always_comb begin
        w_src_ok = ({1'b0, in_src} < c_LANES);
        for (int i = 0; i < N; i++) begin
            w_empty[i] = (r_count[i] == '0);
            w_full[i]  = (r_count[i] == c_DEPTH);
            w_sel[i]   = (in_src == i[SRC_W-1:0]);
            w_vec[16*(N-1-i) +: 16] = w_empty[i] ? 16'h0000 : r_mem[i][r_rd_ptr[i]];
        end
    end

    // Out-of-range tags are always taken so a bad source cannot wedge the stream.
    always_comb begin
        in_ready = 1'b0;
        if (reset_n && (r_state == ST_RUN))
            in_ready = !w_src_ok || !(|(w_full & w_sel));
        w_accept = in_valid && in_ready;
        w_bad    = w_accept && !w_src_ok;
        w_push   = (w_accept && w_src_ok) ? w_sel : '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_partial   = 1'b0;
        w_done      = 1'b0;
        w_pop       = '0;
        case (r_state)
            ST_RUN: begin
                if (!(|w_empty)) begin
                    w_emit = 1'b1;
                    w_pop  = '1;
                end
                if (flush)
                    w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!(&w_empty)) begin
                    w_emit    = 1'b1;
                    w_partial = 1'b1;
                    w_pop     = ~w_empty;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            odata      <= '0;
            ovalid     <= '0;
            opartial   <= 1'b0;
            flush_done <= 1'b0;
            err_src    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            ovalid     <= w_emit ? '1 : '0;
            opartial   <= w_partial;
            flush_done <= w_done;
            err_src    <= err_src | w_bad;
            if (w_emit)
                odata <= w_vec;
            for (int i = 0; i < N; i++) begin
                if (w_push[i])
                    r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                if (w_pop[i])
                    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + 1'b1;
                    2'b01:   r_count[i] <= r_count[i] - 1'b1;
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters alone.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (w_push[i])
                r_mem[i][r_wr_ptr[i]] <= in_data;
        end
    end

`ifdef COLLECTOR_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_vectors <= '0;
            stat_stall   <= '0;
        end else begin
            if (w_emit && (stat_vectors != 32'hFFFF_FFFF))
                stat_vectors <= stat_vectors + 32'd1;
            if (in_valid && !in_ready && (stat_stall != 32'hFFFF_FFFF))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reduce_lane_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reduce_lane_collector
//  Description : Self-checking bench: queue-based reference model, directed
//                scenarios, randomized traffic, plus an N=3 bad-tag instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reduce_lane_collector;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_src = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [63:0] odata;
    logic [3:0]  ovalid;
    logic        opartial;
    logic        err_src;

    logic [15:0] t3_data = '0;
    logic [1:0]  t3_src = '0;
    logic        t3_valid = 1'b0;
    logic        t3_ready;
    logic        t3_flush = 1'b0;
    logic        t3_done;
    logic [47:0] t3_odata;
    logic [2:0]  t3_ovalid;
    logic        t3_partial;
    logic        t3_err;

`ifdef COLLECTOR_STATS_EN
    logic [31:0] stat_vectors, stat_stall, t3_sv, t3_ss;
`endif

    always #5 clock = ~clock;

    reduce_lane_collector #(.N(N), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_src(in_src),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .flush_done(flush_done), .odata(odata), .ovalid(ovalid),
        .opartial(opartial), .err_src(err_src)
`ifdef COLLECTOR_STATS_EN
        , .stat_vectors(stat_vectors), .stat_stall(stat_stall)
`endif
    );

    reduce_lane_collector #(.N(3), .DEPTH(DEPTH)) dut3 (
        .clock(clock), .reset_n(reset_n), .in_data(t3_data), .in_src(t3_src),
        .in_valid(t3_valid), .in_ready(t3_ready), .flush(t3_flush),
        .flush_done(t3_done), .odata(t3_odata), .ovalid(t3_ovalid),
        .opartial(t3_partial), .err_src(t3_err)
`ifdef COLLECTOR_STATS_EN
        , .stat_vectors(t3_sv), .stat_stall(t3_ss)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per lane and a drain-mode flag.
    logic [15:0] mq [N][$];
    bit          m_flush;
    logic [63:0] m_odata;
    logic [3:0]  m_ovalid;
    bit          m_part, m_done, m_err;
    int          m_vecs, m_stall;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready(input logic [1:0] s);
        if (m_flush) return 1'b0;
        if (int'(s) >= N) return 1'b1;
        return mq[s].size() < DEPTH;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_flush = 0; m_odata = '0; m_ovalid = '0;
        m_part = 0; m_done = 0; m_err = 0; m_vecs = 0; m_stall = 0;
    endtask

    task automatic model_edge(input logic v, input logic [1:0] s, input logic [15:0] d, input logic f);
        bit rdy;
        int filled;
        logic [63:0] vec;
        rdy = model_ready(s);
        if (v && !rdy) m_stall++;
        filled = 0;
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) filled++;
        m_ovalid = '0; m_part = 0; m_done = 0;
        vec = '0;
        if (!m_flush) begin
            if (filled == N) begin
                for (int i = 0; i < N; i++) vec[16*(N-1-i) +: 16] = mq[i].pop_front();
                m_odata = vec; m_ovalid = '1; m_vecs++;
            end
            if (f) m_flush = 1;
        end else if (filled > 0) begin
            for (int i = 0; i < N; i++)
                if (mq[i].size() > 0) vec[16*(N-1-i) +: 16] = mq[i].pop_front();
            m_odata = vec; m_ovalid = '1; m_part = 1; m_vecs++;
        end else begin
            m_done = 1; m_flush = 0;
        end
        if (v && rdy) begin
            if (int'(s) < N) mq[s].push_back(d);
            else m_err = 1;
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic [15:0] d, input logic f);
        @(negedge clock);
        in_valid = v; in_src = s; in_data = d; flush = f;
        #1;
        check_val("in_ready", {63'd0, in_ready}, {63'd0, model_ready(s)});
        @(posedge clock);
        model_edge(v, s, d, f);
        #1;
        check_val("ovalid", {60'd0, ovalid}, {60'd0, m_ovalid});
        check_val("odata", odata, m_odata);
        check_val("opartial", {63'd0, opartial}, {63'd0, m_part});
        check_val("flush_done", {63'd0, flush_done}, {63'd0, m_done});
        check_val("err_src", {63'd0, err_src}, {63'd0, m_err});
`ifdef COLLECTOR_STATS_EN
        check_val("stat_vectors", {32'd0, stat_vectors}, 64'(m_vecs));
        check_val("stat_stall", {32'd0, stat_stall}, 64'(m_stall));
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #1;
        check_val("rst_ovalid", {60'd0, ovalid}, 64'd0);
        check_val("rst_odata", odata, 64'd0);
        check_val("rst_opartial", {63'd0, opartial}, 64'd0);
        check_val("rst_flush_done", {63'd0, flush_done}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check_val("rst_err_src", {63'd0, err_src}, 64'd0);
        check_val("rst_err_src_n3", {63'd0, t3_err}, 64'd0);
`ifdef COLLECTOR_STATS_EN
        check_val("rst_stat_vectors", {32'd0, stat_vectors}, 64'd0);
        check_val("rst_stat_stall", {32'd0, stat_stall}, 64'd0);
`endif
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        model_clear();
        apply_reset();

        // Aligned set, one per lane.
        step(1, 2'd0, 16'h3C00, 0);
        step(1, 2'd1, 16'h4000, 0);
        step(1, 2'd2, 16'h4200, 0);
        step(1, 2'd3, 16'h4400, 0);
        idle(1);
        check_val("tp1_odata", odata, 64'h3C00_4000_4200_4400);
        check_val("tp1_ovalid", {60'd0, ovalid}, 64'hF);
        idle(1);
        check_val("tp1_pulse", {60'd0, ovalid}, 64'h0);

        // Lane 1 full then backpressured until a vector pops it.
        for (int k = 0; k < 4; k++) step(1, 2'd1, 16'h1000 + 16'(k), 0);
        step(1, 2'd1, 16'h1FFF, 0);
        check_val("tp2_full_ready", {63'd0, in_ready}, 64'd0);
        step(1, 2'd0, 16'h2000, 0);
        step(1, 2'd2, 16'h2222, 0);
        step(1, 2'd3, 16'h2333, 0);
        step(1, 2'd1, 16'h1ABC, 0);
        check_val("tp2_vec", odata, 64'h2000_1000_2222_2333);
        step(1, 2'd1, 16'h1ABD, 0);
        idle(1);
        step(1, 2'd1, 16'h1ABE, 0);

        // Flush of a partial set.
        apply_reset();
        step(1, 2'd0, 16'h3C00, 0);
        step(1, 2'd2, 16'h4200, 0);
        step(0, 2'd0, 16'h0000, 1);
        step(1, 2'd3, 16'h5555, 0);
        check_val("tp3_odata", odata, 64'h3C00_0000_4200_0000);
        check_val("tp3_opartial", {63'd0, opartial}, 64'd1);
        step(1, 2'd1, 16'h5555, 0);
        check_val("tp3_flush_done", {63'd0, flush_done}, 64'd1);
        step(0, 2'd0, 16'h0, 1);
        idle(2);

        // Out-of-range tag on the three-lane instance.
        @(negedge clock);
        t3_valid = 1'b1; t3_src = 2'd3; t3_data = 16'h3C00;
        #1;
        check_val("n3_ready_bad", {63'd0, t3_ready}, 64'd1);
        @(negedge clock);
        t3_valid = 1'b0;
        check_val("n3_err_set", {63'd0, t3_err}, 64'd1);
        repeat (3) @(negedge clock);
        check_val("n3_err_sticky", {63'd0, t3_err}, 64'd1);
        check_val("n3_no_vec", {61'd0, t3_ovalid}, 64'd0);

        // Eight round-robin sets wrap each lane's pointers twice.
        for (int k = 0; k < 32; k++) step(1, 2'(k % 4), 16'(16'h0100 * (k / 4) + k % 4), 0);
        idle(1);
        check_val("rr_last_vec", odata, 64'h0700_0701_0702_0703);

        // Reset during drain with two lanes still holding data.
        step(1, 2'd0, 16'hAAAA, 0);
        step(1, 2'd0, 16'hAAAB, 0);
        step(1, 2'd1, 16'hBBBB, 0);
        step(1, 2'd1, 16'hBBBC, 0);
        step(0, 2'd0, 16'h0, 1);
        idle(1);
        apply_reset();
        idle(4);

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 800; k++)
            step(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                 16'($urandom), 1'($urandom_range(0, 39) == 0));
        for (int k = 0; k < 20; k++) step(0, 2'd0, 16'h0, !m_flush && k == 0);
        check_val("final_drained", 64'(mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
